// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared states, song entry layout and key-code helpers for note_sequencer
package seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_PLAY   = 3'd2,
      ST_GAP    = 3'd3,
      ST_PAUSED = 3'd4,
      ST_DONE   = 3'd5
   } seq_state_t;

   // Song entry: [7:4] key code, [3:0] duration in beats
   localparam int ENTRY_CODE_HI = 7;
   localparam int ENTRY_CODE_LO = 4;
   localparam int ENTRY_DUR_HI  = 3;
   localparam int ENTRY_DUR_LO  = 0;

   localparam logic [3:0] CODE_REST = 4'd0;
   localparam logic [3:0] CODE_END  = 4'd15;

   // Key codes 1..12 select one key; rest, 13, 14 and END are silent
   function automatic logic [11:0] code_to_onehot(input logic [3:0] code);
      logic [11:0] onehot;
      onehot = '0;
      if (code != CODE_REST && code <= 4'd12) begin
         onehot = 12'd1 << (code - 4'd1);
      end
      return onehot;
   endfunction

   // Isolates the lowest set bit so several held keys still give one tone
   function automatic logic [11:0] lowest_onehot(input logic [11:0] value);
      return value & (~value + 12'd1);
   endfunction

endpackage

// File: rtl/song_rom.sv
// rtl/song_rom.sv - combinational song table, one 8-bit entry per address
module song_rom
   import seq_pkg::*;
#(
   parameter int SONG_LEN = 16,
   parameter int ADDR_W   = 4
) (
   input  logic [ADDR_W-1:0] i_addr,
   output logic [7:0]        o_entry
);

   // Table lookup; anything past the song or unlisted reads as END
   always_comb begin
      o_entry = {CODE_END, 4'd0};
      if (int'(i_addr) < SONG_LEN) begin
         case (int'(i_addr))
            0:       o_entry = 8'h11;
            1:       o_entry = 8'h32;
            2:       o_entry = 8'h01;
            default: o_entry = {CODE_END, 4'd0};
         endcase
      end
   end

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - song playback sequencer with live-keypad priority; SEQ_LOOP_EN repeats the song
module note_sequencer
   import seq_pkg::*;
#(
   parameter int BEAT_CYCLES = 250000,
   parameter int GAP_CYCLES  = 1000,
   parameter int SONG_LEN    = 16,
   parameter int ADDR_W      = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic [11:0]       keypad_live,
   output logic [11:0]       note_out,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] song_idx
);

   localparam int                CNT_W     = $clog2(15 * BEAT_CYCLES + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

   seq_state_t        r_state, r_resume, w_state_nx, w_resume_nx;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nx, w_play_len;
   logic [ADDR_W-1:0] r_addr, w_addr_nx;
   logic [3:0]        r_code, w_code_nx;
   logic [7:0]        w_rom_entry;
   logic [3:0]        w_rom_code, w_rom_dur, w_dur;
   logic [11:0]       r_note, w_seq_nx;
   logic              r_done, w_done_nx, w_end;

   song_rom #(
      .SONG_LEN (SONG_LEN),
      .ADDR_W   (ADDR_W)
   ) u_song_rom (
      .i_addr  (r_addr),
      .o_entry (w_rom_entry)
   );

   assign w_rom_code = w_rom_entry[ENTRY_CODE_HI:ENTRY_CODE_LO];
   assign w_rom_dur  = w_rom_entry[ENTRY_DUR_HI:ENTRY_DUR_LO];
   assign w_dur      = (w_rom_dur == 4'd0) ? 4'd1 : w_rom_dur;
   assign w_play_len = CNT_W'(w_dur) * CNT_W'(BEAT_CYCLES);

   assign note_out = r_note;
   assign done     = r_done;
   assign song_idx = r_addr;
   assign busy     = (r_state == ST_LOAD) || (r_state == ST_PLAY) ||
                     (r_state == ST_GAP)  || (r_state == ST_PAUSED);

   // Next-state logic: playback timing first, then pause, then stop overriding everything
   always_comb begin
      w_state_nx  = r_state;
      w_resume_nx = r_resume;
      w_cnt_nx    = r_cnt;
      w_addr_nx   = r_addr;
      w_code_nx   = r_code;
      w_done_nx   = 1'b0;
      w_end       = 1'b0;

      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               w_state_nx = ST_LOAD;
               w_addr_nx  = '0;
            end
         end
         ST_LOAD: begin
            w_code_nx = w_rom_code;
            if (w_rom_code == CODE_END) begin
               w_end = 1'b1;
            end else begin
               w_state_nx = ST_PLAY;
               w_cnt_nx   = w_play_len;
            end
         end
         ST_PLAY: begin
            if (r_cnt <= CNT_W'(1)) begin
               w_state_nx = ST_GAP;
               w_cnt_nx   = CNT_W'(GAP_CYCLES);
            end else begin
               w_cnt_nx = r_cnt - CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (r_cnt <= CNT_W'(1)) begin
               w_cnt_nx = '0;
               if (r_addr == LAST_ADDR) begin
                  w_end = 1'b1;
               end else begin
                  w_addr_nx  = r_addr + ADDR_W'(1);
                  w_state_nx = ST_LOAD;
               end
            end else begin
               w_cnt_nx = r_cnt - CNT_W'(1);
            end
         end
         ST_PAUSED: begin
            if (start) w_state_nx = r_resume;
         end
         default: w_state_nx = ST_IDLE;
      endcase

      if (w_end) begin
         w_done_nx = 1'b1;
`ifdef SEQ_LOOP_EN
         w_state_nx = ST_LOAD;
         w_addr_nx  = '0;
`else
         w_state_nx = ST_DONE;
`endif
      end

      // The cycle on which pause is seen still counts, so a paused note resumes with exactly its remaining length
      if (pause && ((r_state == ST_PLAY) || (r_state == ST_GAP)) &&
          ((w_state_nx == ST_PLAY) || (w_state_nx == ST_GAP))) begin
         w_resume_nx = w_state_nx;
         w_state_nx  = ST_PAUSED;
      end

      if (stop) begin
         w_state_nx = ST_IDLE;
         w_addr_nx  = '0;
         w_cnt_nx   = '0;
         w_done_nx  = 1'b0;
      end
   end

   // Sequencer tone for the state being entered, so note_out changes on the same edge as the state
   always_comb begin
      w_seq_nx = '0;
      if (w_state_nx == ST_PLAY) w_seq_nx = code_to_onehot(w_code_nx);
   end

   // State registers and the registered keypad/sequencer arbitration
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_resume <= ST_IDLE;
         r_cnt    <= '0;
         r_addr   <= '0;
         r_code   <= CODE_REST;
         r_note   <= '0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_resume <= w_resume_nx;
         r_cnt    <= w_cnt_nx;
         r_addr   <= w_addr_nx;
         r_code   <= w_code_nx;
         r_done   <= w_done_nx;
         r_note   <= (keypad_live != 12'd0) ? lowest_onehot(keypad_live) : w_seq_nx;
      end
   end

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - randomized and directed checks of note_sequencer against a timeline model
module tb_note_sequencer;

   localparam int BEAT = 4;
   localparam int GAP  = 1;
   localparam int SLEN = 16;
`ifdef SEQ_LOOP_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif

   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
   localparam int K_LOAD = 0, K_PLAY = 1, K_GAP = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, stop = 1'b0, pause = 1'b0;
   logic [11:0] keypad_live = '0;
   logic [11:0] note_out;
   logic        busy, done;
   logic [3:0]  song_idx;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0]  rom [SLEN];
   int          tl_kind [$];
   logic [11:0] tl_note [$];
   logic [3:0]  tl_addr [$];

   int          m_mode, m_idx;
   logic [11:0] m_note;
   logic        m_busy, m_done;
   logic [3:0]  m_addr;

   note_sequencer #(
      .BEAT_CYCLES (BEAT),
      .GAP_CYCLES  (GAP),
      .SONG_LEN    (SLEN),
      .ADDR_W      (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop),
      .pause       (pause),
      .keypad_live (keypad_live),
      .note_out    (note_out),
      .busy        (busy),
      .done        (done),
      .song_idx    (song_idx)
   );

   always #5 clk = ~clk;

   // Flatten the song into one element per active cycle
   task automatic build_timeline();
      int code, dur;
      logic [11:0] n;
      for (int a = 0; a < SLEN; a++) rom[a] = 8'hF0;
      rom[0] = 8'h11; rom[1] = 8'h32; rom[2] = 8'h01; rom[3] = 8'hF0;
      for (int a = 0; a < SLEN; a++) begin
         code = int'(rom[a][7:4]);
         dur  = int'(rom[a][3:0]);
         tl_kind.push_back(K_LOAD); tl_note.push_back('0); tl_addr.push_back(4'(a));
         if (code == 15) return;
         if (dur == 0) dur = 1;
         n = (code >= 1 && code <= 12) ? (12'h001 << (code - 1)) : 12'h000;
         for (int c = 0; c < dur * BEAT; c++) begin
            tl_kind.push_back(K_PLAY); tl_note.push_back(n); tl_addr.push_back(4'(a));
         end
         for (int c = 0; c < GAP; c++) begin
            tl_kind.push_back(K_GAP); tl_note.push_back('0); tl_addr.push_back(4'(a));
         end
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_idx = 0; m_addr = '0;
      m_note = '0; m_busy = 1'b0; m_done = 1'b0;
   endtask

   task automatic model_edge(input logic st, input logic sp, input logic ps, input logic [11:0] kp);
      int prev;
      logic [11:0] seq;
      m_done = 1'b0;
      if (sp) begin
         m_mode = M_IDLE; m_idx = 0; m_addr = '0;
      end else begin
         case (m_mode)
            M_IDLE, M_DONE: if (st) begin m_mode = M_RUN; m_idx = 0; m_addr = '0; end
            M_PAUSED:       if (st) m_mode = M_RUN;
            default: begin
               if (m_idx == tl_kind.size() - 1) begin
                  m_done = 1'b1;
                  if (LOOP) begin m_idx = 0; m_addr = '0; end
                  else m_mode = M_DONE;
               end else begin
                  prev   = tl_kind[m_idx];
                  m_idx  = m_idx + 1;
                  m_addr = tl_addr[m_idx];
                  if (ps && prev != K_LOAD && tl_kind[m_idx] != K_LOAD) m_mode = M_PAUSED;
               end
            end
         endcase
      end
      seq = (m_mode == M_RUN && tl_kind[m_idx] == K_PLAY) ? tl_note[m_idx] : 12'h000;
      m_note = seq;
      if (kp != 12'h000) begin
         m_note = '0;
         for (int i = 11; i >= 0; i--) if (kp[i]) m_note = 12'h001 << i;
      end
      m_busy = (m_mode == M_RUN) || (m_mode == M_PAUSED);
   endtask

   task automatic drive_edge(input logic st, input logic sp, input logic ps, input logic [11:0] kp);
      start = st; stop = sp; pause = ps; keypad_live = kp;
      @(posedge clk);
      model_edge(st, sp, ps, kp);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; keypad_live = '0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++;
      if ({note_out, busy, done, song_idx} !== 18'h0) begin
         n_err++;
         $display("FAIL reset_idle: got note=%h busy=%b done=%b idx=%0d want all zero", note_out, busy, done, song_idx);
      end
      drive_edge(1, 0, 0, '0);
      for (int i = 0; i < 3; i++) begin
         drive_edge(0, 0, 0, '0);
         n_vec++;
         if ({note_out, busy, done, song_idx} !== {m_note, m_busy, m_done, m_addr}) begin
            n_err++;
            $display("FAIL reset_preplay cyc%0d: got %h/%b/%b/%0d want %h/%b/%b/%0d", i, note_out, busy, done, song_idx, m_note, m_busy, m_done, m_addr);
         end
      end
      #2 rst = 1'b1;
      #1;
      n_vec++;
      if ({note_out, busy, done, song_idx} !== 18'h0) begin
         n_err++;
         $display("FAIL reset_async: got note=%h busy=%b done=%b idx=%0d want all zero", note_out, busy, done, song_idx);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      drive_edge(1, 0, 0, '0);
      for (int i = 0; i < 8; i++) begin
         drive_edge(0, 0, 0, '0);
         n_vec++;
         if ({note_out, busy, done, song_idx} !== {m_note, m_busy, m_done, m_addr}) begin
            n_err++;
            $display("FAIL reset_restart cyc%0d: got %h/%b/%b/%0d want %h/%b/%b/%0d", i, note_out, busy, done, song_idx, m_note, m_busy, m_done, m_addr);
         end
      end
   endtask

   task automatic test_song();
      int c1 = 0, c4 = 0, cd = 0;
      do_reset();
      drive_edge(0, 0, 0, '0);
      drive_edge(1, 0, 0, '0);
      for (int i = 0; i < 23; i++) begin
         drive_edge(0, 0, 0, '0);
         n_vec++;
         if ({note_out, busy, done, song_idx} !== {m_note, m_busy, m_done, m_addr}) begin
            n_err++;
            $display("FAIL song cyc%0d: got %h/%b/%b/%0d want %h/%b/%b/%0d", i, note_out, busy, done, song_idx, m_note, m_busy, m_done, m_addr);
         end
         if (note_out == 12'h001) c1++;
         if (note_out == 12'h004) c4++;
         if (done) cd++;
      end
      n_vec++;
      if (c1 !== 4) begin n_err++; $display("FAIL song_note1_len: got %0d want 4", c1); end
      n_vec++;
      if (c4 !== 8) begin n_err++; $display("FAIL song_note3_len: got %0d want 8", c4); end
      n_vec++;
      if ({cd, done} !== {32'd1, 1'b1}) begin n_err++; $display("FAIL song_done: got count=%0d last=%b want 1/1", cd, done); end
      n_vec++;
      if (busy !== LOOP) begin n_err++; $display("FAIL song_busy_at_done: got %b want %b", busy, LOOP); end
      drive_edge(0, 1, 0, '0);
   endtask

   task automatic test_pause();
      int c4 = 0;
      bit reached = 0;
      do_reset();
      drive_edge(1, 0, 0, '0);
      for (int i = 0; i < 30 && !reached; i++) begin
         drive_edge(0, 0, 0, '0);
         n_vec++;
         if ({note_out, busy, done, song_idx} !== {m_note, m_busy, m_done, m_addr}) begin
            n_err++;
            $display("FAIL pause_pre cyc%0d: got %h/%b/%b/%0d want %h/%b/%b/%0d", i, note_out, busy, done, song_idx, m_note, m_busy, m_done, m_addr);
         end
         if (note_out == 12'h004) c4++;
         if (c4 == 3) reached = 1;
      end
      n_vec++;
      if (!reached) begin n_err++; $display("FAIL pause_reach_note: got %0d cycles of 004 want 3 within budget", c4); end
      for (int i = 0; i < 5; i++) begin
         drive_edge(0, 0, 1, '0);
         n_vec++;
         if ({note_out, busy, done, song_idx} !== {12'h000, 1'b1, 1'b0, 4'd1}) begin
            n_err++;
            $display("FAIL pause_hold cyc%0d: got %h/%b/%b/%0d want 000/1/0/1", i, note_out, busy, done, song_idx);
         end
      end
      drive_edge(1, 0, 0, '0);
      if (note_out == 12'h004) c4++;
      for (int i = 0; i < 20; i++) begin
         drive_edge(0, 0, 0, '0);
         n_vec++;
         if ({note_out, busy, done, song_idx} !== {m_note, m_busy, m_done, m_addr}) begin
            n_err++;
            $display("FAIL pause_post cyc%0d: got %h/%b/%b/%0d want %h/%b/%b/%0d", i, note_out, busy, done, song_idx, m_note, m_busy, m_done, m_addr);
         end
         if (note_out == 12'h004) c4++;
      end
      n_vec++;
      if (c4 !== 8) begin n_err++; $display("FAIL pause_note_len: got %0d want 8", c4); end
      drive_edge(0, 1, 0, '0);
   endtask

   task automatic test_keypad();
      int c1 = 0, c20 = 0;
      do_reset();
      drive_edge(1, 0, 0, '0);
      for (int i = 0; i < 24; i++) begin
         drive_edge(0, 0, 0, (i == 1 || i == 2) ? 12'h0A0 : 12'h000);
         n_vec++;
         if ({note_out, busy, done, song_idx} !== {m_note, m_busy, m_done, m_addr}) begin
            n_err++;
            $display("FAIL keypad cyc%0d: got %h/%b/%b/%0d want %h/%b/%b/%0d", i, note_out, busy, done, song_idx, m_note, m_busy, m_done, m_addr);
         end
         if (note_out == 12'h001) c1++;
         if (note_out == 12'h020) c20++;
      end
      n_vec++;
      if ({c1, c20} !== {32'd2, 32'd2}) begin
         n_err++;
         $display("FAIL keypad_split: got seq=%0d live=%0d want 2/2", c1, c20);
      end
      drive_edge(0, 1, 0, '0);
   endtask

   task automatic test_start_stop();
      do_reset();
      drive_edge(1, 0, 0, '0);
      drive_edge(0, 0, 0, '0);
      drive_edge(0, 0, 0, '0);
      drive_edge(1, 1, 0, '0);
      n_vec++;
      if ({note_out, busy, done, song_idx} !== 18'h0) begin
         n_err++;
         $display("FAIL start_stop: got note=%h busy=%b done=%b idx=%0d want all zero", note_out, busy, done, song_idx);
      end
      drive_edge(0, 0, 0, '0);
      n_vec++;
      if ({note_out, busy, song_idx} !== {m_note, m_busy, m_addr}) begin
         n_err++;
         $display("FAIL start_stop_idle: got %h/%b/%0d want %h/%b/%0d", note_out, busy, song_idx, m_note, m_busy, m_addr);
      end
   endtask

   task automatic test_random();
      logic st, sp, ps;
      logic [11:0] kp;
      do_reset();
      for (int i = 0; i < 800; i++) begin
         st = ($urandom_range(99) < 10);
         sp = ($urandom_range(99) < 3);
         ps = ($urandom_range(99) < 12);
         kp = ($urandom_range(99) < 10) ? 12'($urandom) : 12'h000;
         drive_edge(st, sp, ps, kp);
         n_vec++;
         if ({note_out, busy, done, song_idx} !== {m_note, m_busy, m_done, m_addr}) begin
            n_err++;
            $display("FAIL random cyc%0d: got %h/%b/%b/%0d want %h/%b/%b/%0d", i, note_out, busy, done, song_idx, m_note, m_busy, m_done, m_addr);
         end
      end
   endtask

   initial begin
      build_timeline();
      model_reset();
      test_reset();
      test_song();
      test_pause();
      test_keypad();
      test_start_stop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
